// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared y86 constants: instruction codes, the "no register"
//                marker and the fetch-state encodings. The controller and the
//                fetch stage both import this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes (byte0[7:4])
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IOPL    = 4'h6;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE   = 4'hF;

  // Fetch-state encodings
  localparam int         FS_W    = 3;
  localparam logic [FS_W-1:0] F_OP    = 3'd0;
  localparam logic [FS_W-1:0] F_REG   = 3'd1;
  localparam logic [FS_W-1:0] F_CONST = 3'd2;
  localparam logic [FS_W-1:0] PRESENT = 3'd3;
  localparam logic [FS_W-1:0] HALTED  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/y86_ilen.sv
`default_nettype none
// ============================================================================
//  Module      : y86_ilen
//  Description : Combinational instruction-length decoder. Maps an icode to
//                whether a register byte and/or a 4-byte constant follow, the
//                total length in bytes, and whether the icode is legal.
//                Illegal icodes report length 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic       o_need_reg,
  output logic       o_need_const,
  output logic [2:0] o_len,
  output logic       o_legal
);

  // Decode the icode into its byte layout
  always_comb begin
    o_need_reg   = 1'b0;
    o_need_const = 1'b0;
    o_len        = 3'd1;
    o_legal      = 1'b1;
    case (i_icode)
      IHALT, INOP: begin
        o_len = 3'd1;
      end
      IRRMOVL, IOPL: begin
        o_need_reg = 1'b1;
        o_len      = 3'd2;
      end
      IIRMOVL: begin
        o_need_reg   = 1'b1;
        o_need_const = 1'b1;
        o_len        = 3'd6;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/y86_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : y86_fetch
//  Description : y86 fetch stage. Reads instruction bytes one at a time over a
//                byte-wide request/strobe memory port, assembles 1/2/6-byte
//                instructions and hands them to decode over valid/ready.
//                Stops fetching after HALT has been accepted.
//                Optional macro Y86_FETCH_BADOP_TRAP_EN: an illegal icode
//                raises instr_error and halts fetch once accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_fetch
  import y86_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [31:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              halted,
  output logic              instr_error
);

  logic [FS_W-1:0]   r_state;
  logic [FS_W-1:0]   w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [3:0]        r_ra;
  logic [3:0]        r_rb;
  logic [31:0]       r_valc;
  logic [ADDR_W-1:0] r_valp;
  logic [1:0]        r_k;

  logic              w_cap;
  logic              w_fetching;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_need_reg;
  logic              w_need_const;
  logic [2:0]        w_len;
  logic              w_legal;
  logic              w_trap;

  // Length decode always looks at the byte being returned; it only matters
  // when the opcode byte is captured in F_OP.
  y86_ilen u_ilen (
    .i_icode      (mem_rdata[7:4]),
    .o_need_reg   (w_need_reg),
    .o_need_const (w_need_const),
    .o_len        (w_len),
    .o_legal      (w_legal)
  );

  // A byte is taken only while our own request is outstanding, so strobes
  // that arrive after a reset abort are ignored.
  assign w_cap      = r_mem_rd & mem_valid;
  assign w_fetching = (r_state == F_OP) || (r_state == F_REG) || (r_state == F_CONST);

  // Byte address for the current fetch state
  always_comb begin
    w_req_addr = r_pc;
    case (r_state)
      F_REG:   w_req_addr = r_pc + ADDR_W'(1);
      F_CONST: w_req_addr = r_pc + ADDR_W'(2) + ADDR_W'(r_k);
      default: w_req_addr = r_pc;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= F_OP;
    else       r_state <= w_next_state;
  end

  // Next-state logic: fetch states advance on byte capture, PRESENT on accept
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      F_OP: begin
        if (w_cap) w_next_state = w_need_reg ? F_REG : PRESENT;
      end
      F_REG: begin
        if (w_cap) w_next_state = (r_icode == IIRMOVL) ? F_CONST : PRESENT;
      end
      F_CONST: begin
        if (w_cap && (r_k == 2'd3)) w_next_state = PRESENT;
      end
      PRESENT: begin
        if (instr_ready)
          w_next_state = ((r_icode == IHALT) || w_trap) ? HALTED : F_OP;
      end
      HALTED:  w_next_state = HALTED;
      default: w_next_state = F_OP;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    instr_valid = (r_state == PRESENT);
    halted      = (r_state == HALTED);
  end

  // Memory request handshake and instruction field assembly
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_icode    <= 4'h0;
      r_ifun     <= 4'h0;
      r_ra       <= RNONE;
      r_rb       <= RNONE;
      r_valc     <= 32'h0;
      r_valp     <= RESET_PC;
      r_k        <= 2'd0;
    end else begin
      // Raise a request in any fetch state with nothing outstanding; the
      // capture cycle drops it, which guarantees one idle cycle in between.
      if (w_fetching && !r_mem_rd) begin
        r_mem_rd   <= 1'b1;
        r_mem_addr <= w_req_addr;
      end
      if (w_cap) r_mem_rd <= 1'b0;

      case (r_state)
        F_OP: if (w_cap) begin
          r_icode <= mem_rdata[7:4];
          r_ifun  <= mem_rdata[3:0];
          r_ra    <= RNONE;
          r_rb    <= RNONE;
          r_valc  <= 32'h0;
          r_valp  <= r_pc + ADDR_W'(w_len);
        end
        F_REG: if (w_cap) begin
          r_ra <= mem_rdata[7:4];
          r_rb <= mem_rdata[3:0];
          r_k  <= 2'd0;
        end
        F_CONST: if (w_cap) begin
          r_valc[{r_k, 3'b000} +: 8] <= mem_rdata;
          r_k                        <= r_k + 2'd1;
        end
        PRESENT: if (instr_ready) begin
          r_pc <= r_valp;
        end
        default: ;
      endcase
    end
  end

`ifdef Y86_FETCH_BADOP_TRAP_EN
  logic r_err;

  // Trap flag: set when an illegal opcode byte is captured, sticky in HALTED
  always_ff @(posedge clock) begin
    if (reset)                        r_err <= 1'b0;
    else if (r_state == F_OP && w_cap) r_err <= ~w_legal;
  end

  assign w_trap      = r_err;
  assign instr_error = r_err;
`else
  logic w_unused_legal;

  assign w_unused_legal = w_legal;
  assign w_trap         = 1'b0;
  assign instr_error    = 1'b0;
`endif

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign icode    = r_icode;
  assign ifun     = r_ifun;
  assign rA       = r_ra;
  assign rB       = r_rb;
  assign valC     = r_valc;
  assign valP     = r_valp;

  logic w_unused_const;
  assign w_unused_const = w_need_const;

endmodule
`default_nettype wire

// File: tb/tb_y86_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y86_fetch
//  Description : Self-checking bench for y86_fetch: a latency-programmable
//                byte memory responder, a table of single-instruction vectors
//                and hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_fetch;

`ifdef Y86_FETCH_BADOP_TRAP_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [31:0] valC, valP;
  logic        halted, instr_error;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mem [64];
  int          lat = 1;
  int          hcnt = 0;
  int          txn = 0;
  bit          inject_stale = 1'b0;
  logic [31:0] held_addr = 32'h0;

  y86_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .valP        (valP),
    .halted      (halted),
    .instr_error (instr_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acts 1 time unit after each edge; answers a request
  // after it has been seen for 'lat' cycles and checks the address holds.
  always begin
    @(posedge clock);
    #1;
    mem_valid = 1'b0;
    if (inject_stale) begin
      mem_valid    = 1'b1;
      mem_rdata    = 8'hAA;
      inject_stale = 1'b0;
      hcnt         = 0;
    end else if (mem_rd) begin
      if (hcnt == 0) held_addr = mem_addr;
      else chk("addr_stable", {32'h0, mem_addr}, {32'h0, held_addr});
      hcnt++;
      if (hcnt == lat) begin
        mem_valid = 1'b1;
        mem_rdata = mem[mem_addr[5:0]];
        txn++;
      end
    end else begin
      hcnt = 0;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [47:0] prog);
    for (int i = 0; i < 64; i++) mem[i] = 8'h10;
    for (int i = 0; i < 6; i++) mem[i] = prog[8*i +: 8];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    txn   = 0;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 80) begin
      step();
      n++;
    end
    if (!instr_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  typedef struct {
    logic [47:0] prog;
    int          lat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [31:0] valc, valp;
    int          ntx;
    logic        err;
  } vec_t;

  vec_t vecs[6];
  int   rd_cnt;

  initial begin
    vecs[0] = '{48'h10,           1, 4'h1, 4'h0, 4'hF, 4'hF, 32'h0,        32'd1, 1, 1'b0};
    vecs[1] = '{48'h12345678F330, 1, 4'h3, 4'h0, 4'hF, 4'h3, 32'h12345678, 32'd6, 6, 1'b0};
    vecs[2] = '{48'h4520,         3, 4'h2, 4'h0, 4'h4, 4'h5, 32'h0,        32'd2, 2, 1'b0};
    vecs[3] = '{48'hAB61,         2, 4'h6, 4'h1, 4'hA, 4'hB, 32'h0,        32'd2, 2, 1'b0};
    vecs[4] = '{48'hDEADBEEF0730, 2, 4'h3, 4'h0, 4'h0, 4'h7, 32'hDEADBEEF, 32'd6, 6, 1'b0};
    vecs[5] = '{48'hF0,           1, 4'hF, 4'h0, 4'hF, 4'hF, 32'h0,        32'd1, 1, ERR_EXP};

    // Reset values
    load(48'h10);
    step();
    step();
    chk("rst_mem_rd", {63'h0, mem_rd}, 64'd0);
    chk("rst_valid",  {63'h0, instr_valid}, 64'd0);
    chk("rst_icode",  {60'h0, icode}, 64'h0);
    chk("rst_ifun",   {60'h0, ifun}, 64'h0);
    chk("rst_rA",     {60'h0, rA}, 64'hF);
    chk("rst_rB",     {60'h0, rB}, 64'hF);
    chk("rst_valC",   {32'h0, valC}, 64'h0);
    chk("rst_valP",   {32'h0, valP}, 64'h0);
    chk("rst_halted", {63'h0, halted}, 64'd0);
    chk("rst_err",    {63'h0, instr_error}, 64'd0);

    // Table of single instructions
    for (int v = 0; v < 6; v++) begin
      load(vecs[v].prog);
      lat = vecs[v].lat;
      do_reset();
      wait_valid("vec");
      chk("vec_icode", {60'h0, icode}, {60'h0, vecs[v].icode});
      chk("vec_ifun",  {60'h0, ifun},  {60'h0, vecs[v].ifun});
      chk("vec_rA",    {60'h0, rA},    {60'h0, vecs[v].ra});
      chk("vec_rB",    {60'h0, rB},    {60'h0, vecs[v].rb});
      chk("vec_valC",  {32'h0, valC},  {32'h0, vecs[v].valc});
      chk("vec_valP",  {32'h0, valP},  {32'h0, vecs[v].valp});
      chk("vec_ntx",   64'(txn),       64'(vecs[v].ntx));
      chk("vec_err",   {63'h0, instr_error}, {63'h0, vecs[v].err});
      accept();
    end

    // NOP then HALT with ready held high; no requests after HALT
    load(48'h0010);
    lat = 1;
    instr_ready = 1'b1;
    do_reset();
    wait_valid("nop");
    chk("nop_icode", {60'h0, icode}, 64'h1);
    chk("nop_valP",  {32'h0, valP}, 64'd1);
    step();
    wait_valid("halt");
    chk("halt_icode", {60'h0, icode}, 64'h0);
    chk("halt_valP",  {32'h0, valP}, 64'd2);
    step();
    chk("halt_halted", {63'h0, halted}, 64'd1);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_rd) rd_cnt++;
    end
    chk("halt_no_rd", 64'(rd_cnt), 64'd0);
    instr_ready = 1'b0;

    // OPL stalled by decode for 5 cycles, then next fetch at address 2
    load(48'h1260);
    do_reset();
    wait_valid("stall");
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {63'h0, instr_valid}, 64'd1);
      chk("stall_fields", {44'h0, icode, ifun, rA, rB, valP[3:0]}, {44'h0, 4'h6, 4'h0, 4'h1, 4'h2, 4'h2});
      if (mem_rd) rd_cnt++;
    end
    chk("stall_no_rd", 64'(rd_cnt), 64'd0);
    accept();
    chk("stall_drop_valid", {63'h0, instr_valid}, 64'd0);
    step();
    chk("next_rd",   {63'h0, mem_rd}, 64'd1);
    chk("next_addr", {32'h0, mem_addr}, 64'd2);

    // Reset during the third constant byte, stale strobe afterwards
    load(48'h12345678F330);
    lat = 3;
    do_reset();
    begin
      int n;
      n = 0;
      while (!(mem_rd && mem_addr == 32'd4) && n < 80) begin
        step();
        n++;
      end
      chk("abort_reach", {63'h0, mem_rd}, 64'd1);
    end
    reset        = 1'b1;
    inject_stale = 1'b1;
    step();
    chk("abort_mem_rd", {63'h0, mem_rd}, 64'd0);
    chk("abort_valC",   {32'h0, valC}, 64'h0);
    chk("abort_rArB",   {56'h0, rA, rB}, 64'hFF);
    chk("abort_valP",   {32'h0, valP}, 64'h0);
    reset = 1'b0;
    txn   = 0;
    step();
    chk("abort_rd",   {63'h0, mem_rd}, 64'd1);
    chk("abort_addr", {32'h0, mem_addr}, 64'd0);
    wait_valid("abort");
    chk("abort_icode", {60'h0, icode}, 64'h3);
    chk("abort_valC2", {32'h0, valC}, 64'h12345678);
    chk("abort_ntx",   64'(txn), 64'd6);
    accept();

    // Illegal opcode followed by NOP
    load(48'h10F0);
    lat = 1;
    do_reset();
    wait_valid("bad");
    chk("bad_err",  {63'h0, instr_error}, {63'h0, ERR_EXP});
    chk("bad_valP", {32'h0, valP}, 64'd1);
    accept();
`ifdef Y86_FETCH_BADOP_TRAP_EN
    chk("bad_halted", {63'h0, halted}, 64'd1);
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_rd) rd_cnt++;
    end
    chk("bad_no_rd",  64'(rd_cnt), 64'd0);
    chk("bad_sticky", {63'h0, instr_error}, 64'd1);
`else
    wait_valid("after_bad");
    chk("after_bad_icode", {60'h0, icode}, 64'h1);
    chk("after_bad_valP",  {32'h0, valP}, 64'd2);
    chk("after_bad_halt",  {63'h0, halted}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
